fixed_exp_neg_pipe: RTL and testbench

//  Pipelined fixed-point e^(-x) unit for softmax/normalisation datapaths; generalises the 4-bit integer exp LUT.

---
 rtl/fixed_exp_neg_pipe.sv | 117 +++++++++++
 tb/tb_fixed_exp_neg_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_exp_neg_pipe.sv
// Two-stage pipelined e^(-x) for unsigned fixed-point x: integer and fraction ROM lookup, then
// one rounded multiply. Both stages use valid/ready handshaking that passes backpressure upstream.
module fixed_exp_neg_pipe #(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 4,
    parameter int DATA_OUT_0_PRECISION_1 = 16,
    parameter int FRAC_LUT_BITS          = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_1:0]   data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
);

    localparam int P0 = DATA_IN_0_PRECISION_0;
    localparam int P1 = DATA_IN_0_PRECISION_1;
    localparam int IW = P0 - P1;
    localparam int OF = DATA_OUT_0_PRECISION_1;
    localparam int OW = OF + 1;
    localparam int FB = FRAC_LUT_BITS;
    localparam int DI = 1 << IW;
    localparam int DF = 1 << FB;
    localparam int PW = 2 * OW;

    localparam logic [OW-1:0] ONE  = OW'(1) << OF;
    localparam logic [PW-1:0] HALF = PW'(1) << (OF - 1);
    localparam logic [PW-1:0] ONE_W = PW'(1) << OF;

    // round(2^OF * e^-(num / 2^frac_bits)); the series is summed for e^+t and inverted so that
    // large arguments stay well-conditioned.
    function automatic logic [OW-1:0] exp_q(input int num, input int frac_bits);
        real t;
        real term;
        real sum;
        t    = real'(num) / real'(1 << frac_bits);
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n < 200; n++) begin
            term = term * t / real'(n);
            sum  = sum + term;
        end
        return OW'($rtoi(real'(1 << OF) / sum + 0.5));
    endfunction

    logic [OW-1:0] lut_i [DI];
    logic [OW-1:0] lut_f [DF];

    for (genvar k = 0; k < DI; k++) begin : g_lut_i
        localparam logic [OW-1:0] VAL = exp_q(k, 0);
        assign lut_i[k] = VAL;
    end

    for (genvar k = 0; k < DF; k++) begin : g_lut_f
        localparam logic [OW-1:0] VAL = exp_q(k, FB);
        assign lut_f[k] = VAL;
    end

    logic [IW-1:0] idx_i;
    logic [FB-1:0] idx_f;
    assign idx_i = data_in_0[P0-1:P1];
    assign idx_f = data_in_0[P1-1 -: FB];

    logic          v1;
    logic          v2;
    logic [OW-1:0] s1_a;
    logic [OW-1:0] s1_b;
    logic [OW-1:0] s2_q;
    logic          adv1;
    logic          adv2;

    assign adv2 = !v2 || data_out_0_ready;
    assign adv1 = !v1 || adv2;
    assign data_in_0_ready  = adv1;
    assign data_out_0_valid = v2;
    assign data_out_0       = s2_q;

    logic [PW-1:0] prod;
    logic [PW-1:0] shifted;
    logic [OW-1:0] res;

    always_comb begin
        prod    = PW'(s1_a) * PW'(s1_b);
        shifted = (prod + HALF) >> OF;
        res     = shifted[OW-1:0];
        // A zero integer entry means e^-x underflows; force 0 explicitly.
        if (s1_a == '0) begin
            res = '0;
        end else if (shifted > ONE_W) begin
            res = ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            s1_a <= '0;
            s1_b <= '0;
            s2_q <= '0;
        end else begin
            if (adv1) begin
                v1   <= data_in_0_valid;
                s1_a <= lut_i[idx_i];
                s1_b <= lut_f[idx_f];
            end
            if (adv2) begin
                v2   <= v1;
                s2_q <= res;
            end
        end
    end

endmodule

// File: tb/tb_fixed_exp_neg_pipe.sv
// Directed and randomised checks of fixed_exp_neg_pipe against a real-arithmetic reference:
// known values, full sweep, streaming latency, stall/hold, random handshakes and mid-stream reset.
module tb_fixed_exp_neg_pipe;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] out_data;
    logic        out_valid;
    logic        out_ready;

    fixed_exp_neg_pipe dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (in_data),
        .data_in_0_valid  (in_valid),
        .data_in_0_ready  (in_ready),
        .data_out_0       (out_data),
        .data_out_0_valid (out_valid),
        .data_out_0_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        nchk++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd_q(input real v);
        return longint'($rtoi(65536.0 * v + 0.5));
    endfunction

    function automatic longint model(input int x);
        longint li;
        longint lf;
        longint r;
        li = rnd_q($exp(-real'(x >> 4)));
        lf = rnd_q($exp(-real'(x & 15) / 16.0));
        r  = (li * lf + 32768) >> 16;
        if (r > 65536) r = 65536;
        if (li == 0) r = 0;
        return r;
    endfunction

    longint exp_val [$];
    int     exp_cyc [$];
    longint got_log [$];
    int     cyc = 0;
    bit     lat_chk = 0;
    bit     stall_prev = 0;
    logic [16:0] stall_data;
    int     nacc = 0;

    task automatic step(input logic vin, input logic [7:0] x, input logic rdy);
        longint e;
        int     c;
        @(posedge clk);
        #1;
        in_valid  = vin;
        in_data   = x;
        out_ready = rdy;
        @(negedge clk);
        cyc++;
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, stall_data);
        end
        if (out_valid && out_ready) begin
            if (exp_val.size() == 0) begin
                chk("spurious_beat", out_valid, 0);
            end else begin
                e = exp_val.pop_front();
                c = exp_cyc.pop_front();
                got_log.push_back(longint'(out_data));
                chk("data", out_data, e);
                if (lat_chk) chk("latency", cyc - c, 2);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (vin && in_ready) begin
            nacc++;
            exp_val.push_back(model(int'(x)));
            exp_cyc.push_back(cyc);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_val.size() != 0 && n < 50) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        if (exp_val.size() != 0) chk("drain_timeout", exp_val.size(), 0);
        step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        // known points, including underflow at x=0xFF
        lat_chk = 1;
        got_log.delete();
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h10, 1'b1);
        step(1'b1, 8'h08, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        drain();
        chk("n_known", got_log.size(), 5);
        if (got_log.size() == 5) begin
            chk("x00", got_log[0], 65536);
            chk("x10", got_log[1], 24109);
            chk("x08", got_log[2], 39750);
            chk("xFF", got_log[3], 0);
            chk("x01", got_log[4], 61565);
        end

        // full sweep
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1);
        drain();

        // 16-beat stream, consecutive outputs at latency 2
        got_log.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i * 7 + 3), 1'b1);
        drain();
        chk("stream_count", got_log.size(), 16);
        lat_chk = 0;

        // stall downstream for 5 cycles while the source keeps offering
        nacc = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        chk("stall_accepts", nacc, 2);
        chk("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
        drain();

        // random handshakes
        nacc = 0;
        for (int n = 0; n < 40000 && nacc < 10000; n++)
            step(1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 9) < 7));
        chk("random_beats", nacc, 10000);
        drain();

        // reset with two beats in flight
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("pre_rst_valid", out_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        exp_val.delete();
        exp_cyc.delete();
        stall_prev = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("no_stale", out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
